// File: rtl/fifo_rd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl_pkg
//  Shared definitions for the async FIFO pointer logic.
//  Holds the default geometry and the Gray/binary conversion helpers.
//  The helpers work on a wide word. Callers zero-extend a pointer into it
//  and size-cast the result back down. This keeps one function usable for
//  any ADDRSIZE.
// -----------------------------------------------------------------------------
package fifo_rd_ctrl_pkg;

   localparam int DEF_DATASIZE  = 8;
   localparam int DEF_ADDRSIZE  = 4;
   localparam int DEF_MEM_DEPTH = 16;
   localparam int DEF_AE_LEVEL  = 2;

   typedef logic [31:0] ptr_wide_t;

   function automatic ptr_wide_t bin2gray(input ptr_wide_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic ptr_wide_t gray2bin(input ptr_wide_t gray);
      ptr_wide_t bin;
      bin = gray;
      for (int i = 1; i < 32; i++) begin
         bin = bin ^ (gray >> i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// -----------------------------------------------------------------------------
// fifo_sync_2ff
//  Two-stage flop synchroniser for a Gray-coded pointer crossing clock domains.
//  Only one bit of the pointer changes per step. Sampling it with two flops
//  therefore yields either the old or the new value, never a mix.
//  Ports:
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset
//   i_d      asynchronous input word
//   o_q      synchronised output word (two i_clk edges of latency)
// -----------------------------------------------------------------------------
module fifo_sync_2ff #(
   parameter int WIDTH = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//  Read-domain controller of the async FIFO.
//  - Owns the binary and Gray read pointers and the memory read address.
//  - Synchronises the write Gray pointer into the read clock.
//  - Derives empty, almost-empty and fill count from the synchronised pointer.
//  - Registers the async memory read data into one output stage with a valid strobe.
//  Ports:
//   i_rd_clk, i_rd_rst_n  read clock, async active-low reset
//   i_rd_en               read request
//   i_wr_ptr_gray         write Gray pointer (asynchronous)
//   i_mem_data            memory read data for o_rd_addr
//   o_rd_addr             memory read address
//   o_rd_ptr_gray         registered read Gray pointer to the write domain
//   o_rd_data/o_rd_valid  registered read data and its one-cycle strobe
//   o_empty, o_almost_empty, o_rd_count  registered status
//   o_rd_underflow        one-cycle pulse on a read request while empty
// -----------------------------------------------------------------------------
module fifo_rd_ctrl
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int DATASIZE  = DEF_DATASIZE,
   parameter int ADDRSIZE  = DEF_ADDRSIZE,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int AE_LEVEL  = DEF_AE_LEVEL
) (
   input  logic                i_rd_clk,
   input  logic                i_rd_rst_n,
   input  logic                i_rd_en,
   input  logic [ADDRSIZE:0]   i_wr_ptr_gray,
   input  logic [DATASIZE-1:0] i_mem_data,
   output logic [ADDRSIZE-1:0] o_rd_addr,
   output logic [ADDRSIZE:0]   o_rd_ptr_gray,
   output logic [DATASIZE-1:0] o_rd_data,
   output logic                o_rd_valid,
   output logic                o_empty,
   output logic                o_almost_empty,
   output logic [ADDRSIZE:0]   o_rd_count,
   output logic                o_rd_underflow
);

   localparam int PTR_W = ADDRSIZE + 1;
   localparam logic [PTR_W-1:0] AE_THRESH = PTR_W'(AE_LEVEL);

   if (MEM_DEPTH != (1 << ADDRSIZE)) begin : g_bad_depth
      $error("fifo_rd_ctrl: MEM_DEPTH must equal 2**ADDRSIZE");
   end

   logic [PTR_W-1:0]    rd_bin_q, rd_bin_d;
   logic [PTR_W-1:0]    rd_gray_q, rd_gray_d;
   logic [PTR_W-1:0]    count_q, count_d;
   logic [DATASIZE-1:0] rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                empty_q, empty_d;
   logic                ae_q, ae_d;
   logic                underflow_q, underflow_d;
   logic                rd_inc;
   logic [PTR_W-1:0]    wq2;
   logic [PTR_W-1:0]    wq2_bin;

   fifo_sync_2ff #(.WIDTH(PTR_W)) u_wr_ptr_sync (
      .i_clk   (i_rd_clk),
      .i_rst_n (i_rd_rst_n),
      .i_d     (i_wr_ptr_gray),
      .o_q     (wq2)
   );

   always_comb begin
      // NOTE: every signal below gets an unconditional value before any
      // conditional logic, so no path leaves one unassigned and no latch is inferred.
      rd_inc      = i_rd_en & ~empty_q;
      rd_bin_d    = rd_bin_q + PTR_W'(rd_inc);
      rd_gray_d   = PTR_W'(bin2gray(ptr_wide_t'(rd_bin_d)));
      wq2_bin     = PTR_W'(gray2bin(ptr_wide_t'(wq2)));
      rd_data_d   = rd_data_q;
      rd_valid_d  = rd_inc;
      underflow_d = i_rd_en & empty_q;

      if (rd_inc) begin
         rd_data_d = i_mem_data;
      end

      // Flags look ahead to the post-increment pointer. A read that drains
      // the last word raises empty at the same edge.
      empty_d = (rd_gray_d == wq2);
      count_d = wq2_bin - rd_bin_d;
      ae_d    = (count_d <= AE_THRESH);
   end

   always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
      if (!i_rd_rst_n) begin
         rd_bin_q    <= '0;
         rd_gray_q   <= '0;
         count_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         empty_q     <= 1'b1;
         ae_q        <= 1'b1;
         underflow_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample pre-edge
         // values, whatever the statement order.
         rd_bin_q    <= rd_bin_d;
         rd_gray_q   <= rd_gray_d;
         count_q     <= count_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         empty_q     <= empty_d;
         ae_q        <= ae_d;
         underflow_q <= underflow_d;
      end
   end

   assign o_rd_addr      = rd_bin_q[ADDRSIZE-1:0];
   assign o_rd_ptr_gray  = rd_gray_q;
   assign o_rd_data      = rd_data_q;
   assign o_rd_valid     = rd_valid_q;
   assign o_empty        = empty_q;
   assign o_almost_empty = ae_q;
   assign o_rd_count     = count_q;
   assign o_rd_underflow = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//  Directed bench for fifo_rd_ctrl.
//  The bench models the write side: a memory array and a write pointer.
//  Every word written is pushed onto a scoreboard queue. A monitor pops one
//  entry for each o_rd_valid strobe and compares it with o_rd_data.
//  Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rd_en;
   logic [4:0] wr_gray;
   logic [7:0] mem_data;
   logic [3:0] rd_addr;
   logic [4:0] rd_ptr_gray;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       empty;
   logic       almost_empty;
   logic [4:0] rd_count;
   logic       underflow;

   logic [7:0] mem [16];
   logic [7:0] sb_q [$];
   logic [4:0] wr_bin;
   logic [4:0] rd_model;
   int         n_cmp = 0;
   int         n_err = 0;
   int         n_valid = 0;

   always #5 clk = ~clk;

   assign mem_data = mem[rd_addr];

   fifo_rd_ctrl #(
      .DATASIZE(8), .ADDRSIZE(4), .MEM_DEPTH(16), .AE_LEVEL(2)
   ) dut (
      .i_rd_clk       (clk),
      .i_rd_rst_n     (rst_n),
      .i_rd_en        (rd_en),
      .i_wr_ptr_gray  (wr_gray),
      .i_mem_data     (mem_data),
      .o_rd_addr      (rd_addr),
      .o_rd_ptr_gray  (rd_ptr_gray),
      .o_rd_data      (rd_data),
      .o_rd_valid     (rd_valid),
      .o_empty        (empty),
      .o_almost_empty (almost_empty),
      .o_rd_count     (rd_count),
      .o_rd_underflow (underflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Write-side model: store the word, queue it, then advance the Gray pointer.
   task automatic push_word(input logic [7:0] d);
      mem[wr_bin[3:0]] = d;
      sb_q.push_back(d);
      wr_bin  = wr_bin + 5'd1;
      wr_gray = wr_bin ^ (wr_bin >> 1);
   endtask

   task automatic wait_not_empty(input int max_cycles);
      for (int c = 0; c < max_cycles; c++) begin
         if (empty === 1'b0) break;
         tick();
      end
      check("wait_not_empty", empty, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_empty"},     empty,        1'b1);
      check({tag, "_ae"},        almost_empty, 1'b1);
      check({tag, "_count"},     rd_count,     5'd0);
      check({tag, "_addr"},      rd_addr,      4'd0);
      check({tag, "_gray"},      rd_ptr_gray,  5'd0);
      check({tag, "_valid"},     rd_valid,     1'b0);
      check({tag, "_data"},      rd_data,      8'd0);
      check({tag, "_underflow"}, underflow,    1'b0);
   endtask

   // Scoreboard monitor: one queued word per valid strobe.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rd_valid === 1'b1) begin
         n_valid++;
         check("sb_has_entry", (sb_q.size() != 0), 1'b1);
         if (sb_q.size() != 0) begin
            check("sb_rd_data", rd_data, sb_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] prev_gray;
      logic [3:0] prev_addr;
      logic       seen_wrap;
      int         valid_base;

      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      rst_n   = 1'b0;
      rd_en   = 1'b0;
      wr_bin  = 5'd0;
      wr_gray = 5'd0;
      tick();
      tick();

      // 1. Reset values
      check_reset_values("reset");
      rst_n = 1'b1;
      tick();

      // 2. Single word; empty must clear at the third edge after the pointer moves
      push_word(8'hA5);
      tick();
      tick();
      check("single_empty_edge2", empty, 1'b1);
      tick();
      check("single_empty_edge3", empty, 1'b0);
      check("single_count", rd_count, 5'd1);
      check("single_ae", almost_empty, 1'b1);
      check("single_addr_before", rd_addr, 4'd0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("single_valid", rd_valid, 1'b1);
      check("single_data", rd_data, 8'hA5);
      check("single_empty_after", empty, 1'b1);
      check("single_addr_after", rd_addr, 4'd1);
      check("single_gray_after", rd_ptr_gray, 5'b00001);
      check("single_count_after", rd_count, 5'd0);
      tick();
      check("single_valid_pulse", rd_valid, 1'b0);
      check("single_data_hold", rd_data, 8'hA5);

      // 3. Underflow
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("uf_pulse", underflow, 1'b1);
      check("uf_valid", rd_valid, 1'b0);
      check("uf_addr", rd_addr, 4'd1);
      tick();
      check("uf_pulse_end", underflow, 1'b0);
      check("uf_addr_hold", rd_addr, 4'd1);

      // Reset both domains before the full-FIFO test
      rst_n   = 1'b0;
      wr_bin  = 5'd0;
      wr_gray = 5'd0;
      sb_q.delete();
      tick();
      check_reset_values("rst2");
      rst_n = 1'b1;
      tick();

      // 4. Full drain
      for (int i = 0; i < 16; i++) push_word(8'($urandom_range(0, 255)));
      check("full_wr_gray", wr_gray, 5'b11000);
      tick();
      tick();
      tick();
      check("full_count", rd_count, 5'd16);
      check("full_ae", almost_empty, 1'b0);
      check("full_empty", empty, 1'b0);
      valid_base = n_valid;
      rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("drain_addr", rd_addr, 32'(i));
         check("drain_count", rd_count, 32'(16 - i));
         check("drain_ae", almost_empty, (16 - i) <= 2);
         check("drain_empty", empty, 1'b0);
         if (i > 0) check("drain_valid", rd_valid, 1'b1);
         tick();
      end
      rd_en = 1'b0;
      check("drain_last_valid", rd_valid, 1'b1);
      check("drain_final_empty", empty, 1'b1);
      check("drain_final_count", rd_count, 5'd0);
      check("drain_final_addr", rd_addr, 4'd0);
      check("drain_final_gray", rd_ptr_gray, 5'b11000);
      tick();
      check("drain_valid_end", rd_valid, 1'b0);
      check("drain_valid_total", n_valid - valid_base, 16);

      // 5. Wrap: 40 write/read pairs from rd_bin = 16
      rd_model  = 5'd16;
      seen_wrap = 1'b0;
      for (int k = 0; k < 40; k++) begin
         push_word(8'($urandom_range(0, 255)));
         wait_not_empty(6);
         prev_gray = rd_ptr_gray;
         prev_addr = rd_addr;
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
         rd_model = rd_model + 5'd1;
         check("wrap_valid", rd_valid, 1'b1);
         check("wrap_addr", rd_addr, rd_model[3:0]);
         check("wrap_gray", rd_ptr_gray, rd_model ^ (rd_model >> 1));
         check("wrap_hamming", $countones(prev_gray ^ rd_ptr_gray), 1);
         check("wrap_empty", empty, 1'b1);
         if (prev_addr == 4'd15 && rd_addr == 4'd0) seen_wrap = 1'b1;
      end
      check("wrap_seen", seen_wrap, 1'b1);

      // 6. Reset in the middle of a burst
      for (int i = 0; i < 5; i++) push_word(8'($urandom_range(0, 255)));
      for (int c = 0; c < 6; c++) begin
         if (rd_count === 5'd5) break;
         tick();
      end
      check("mid_count5", rd_count, 5'd5);
      rd_en = 1'b1;
      tick();
      @(posedge clk);
      #2;
      rst_n   = 1'b0;
      wr_bin  = 5'd0;
      wr_gray = 5'd0;
      sb_q.delete();
      #1;
      check_reset_values("midrst");
      rd_en = 1'b0;
      tick();
      tick();
      check("midrst_no_valid", rd_valid, 1'b0);
      rst_n = 1'b1;
      tick();
      check("restart_valid", rd_valid, 1'b0);
      check("restart_addr", rd_addr, 4'd0);
      push_word(8'h3C);
      wait_not_empty(6);
      check("restart_addr_before", rd_addr, 4'd0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("restart_rd_valid", rd_valid, 1'b1);
      check("restart_data", rd_data, 8'h3C);
      check("restart_addr_after", rd_addr, 4'd1);
      tick();
      check("sb_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
